// File: rtl/des_key_rotator_if.sv
// des_key_rotator_if
//   Bundles the load request, the per-round output handshake and the status
//   flags of des_key_rotator. clk/rst_n stay plain ports on the modules.
//   master : the rotator (drives round data, status)
//   slave  : the key-load source / round consumer
//   Signals: start, decrypt, c_in, d_in, round_ready   (into rotator)
//            round_valid, round_idx, c_out, d_out,
//            busy, done, chk_err                      (out of rotator)
interface des_key_rotator_if #(
  parameter int HALF_W = 28,
  parameter int RIDX_W = 4
);
  logic              start;
  logic              decrypt;
  logic [HALF_W-1:0] c_in;
  logic [HALF_W-1:0] d_in;
  logic              round_ready;
  logic              round_valid;
  logic [RIDX_W-1:0] round_idx;
  logic [HALF_W-1:0] c_out;
  logic [HALF_W-1:0] d_out;
  logic              busy;
  logic              done;
  logic              chk_err;

  modport master (
    input  start, decrypt, c_in, d_in, round_ready,
    output round_valid, round_idx, c_out, d_out, busy, done, chk_err
  );

  modport slave (
    output start, decrypt, c_in, d_in, round_ready,
    input  round_valid, round_idx, c_out, d_out, busy, done, chk_err
  );
endinterface

// File: rtl/des_key_rotator.sv
// des_key_rotator
//   DES key-schedule rotator. Loads the 28-bit C/D halves (after PC-1) and
//   presents one rotated C/D pair per round over a valid/ready handshake.
//   Encrypt rotates left by amt(i); decrypt outputs the loaded value at
//   step 0 and then rotates right by amt(ROUNDS-i). amt(i) = 1 when
//   SHIFT_ONE_MASK[i] is set, otherwise 2.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : des_key_rotator_if.master (load inputs, round outputs,
//              busy/done/chk_err status)
//   Optional: define ROT_CLOSURE_CHECK_EN to build the rotation-closure check
//   driving chk_err in the FIN cycle; otherwise chk_err is tied low.
module des_key_rotator #(
  parameter int                HALF_W         = 28,
  parameter int                ROUNDS         = 16,
  parameter logic [ROUNDS-1:0] SHIFT_ONE_MASK = 16'h8103,
  parameter int                RIDX_W         = 4
) (
  input logic               clk,
  input logic               rst_n,
  des_key_rotator_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OUT  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);
  // Modulo-2^RIDX_W; ROUNDS - idx for idx in 1..ROUNDS-1 always fits.
  localparam logic [RIDX_W-1:0] ROUNDS_M = RIDX_W'(ROUNDS);

  logic [1:0]        state;
  logic              mode;
  logic [HALF_W-1:0] c_q;
  logic [HALF_W-1:0] d_q;
  logic [RIDX_W-1:0] idx_q;

  logic [RIDX_W-1:0] nxt_idx;
  logic [RIDX_W-1:0] dec_sel;
  logic              nxt_one;
  logic              accept_last;

  function automatic logic [HALF_W-1:0] rot(input logic [HALF_W-1:0] v,
                                             input logic              right,
                                             input logic              by_one);
    logic [HALF_W-1:0] r;
    if (right)
      r = by_one ? {v[0], v[HALF_W-1:1]} : {v[1:0], v[HALF_W-1:2]};
    else
      r = by_one ? {v[HALF_W-2:0], v[HALF_W-1]} : {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]};
    return r;
  endfunction

  always_comb begin
    nxt_idx     = idx_q + 1'b1;
    dec_sel     = ROUNDS_M - nxt_idx;
    nxt_one     = mode ? SHIFT_ONE_MASK[dec_sel] : SHIFT_ONE_MASK[nxt_idx];
    accept_last = (state == OUT) && bus.round_ready && (idx_q == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode  <= 1'b0;
      c_q   <= '0;
      d_q   <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode  <= bus.decrypt;
            idx_q <= '0;
            c_q   <= bus.decrypt ? bus.c_in : rot(bus.c_in, 1'b0, SHIFT_ONE_MASK[0]);
            d_q   <= bus.decrypt ? bus.d_in : rot(bus.d_in, 1'b0, SHIFT_ONE_MASK[0]);
            state <= OUT;
          end
        end
        OUT: begin
          if (bus.round_ready) begin
            if (idx_q == LAST_IDX) begin
              state <= FIN;
            end else begin
              idx_q <= nxt_idx;
              c_q   <= rot(c_q, mode, nxt_one);
              d_q   <= rot(d_q, mode, nxt_one);
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.round_valid = (state == OUT);
  assign bus.busy        = (state == OUT);
  assign bus.done        = (state == FIN);
  assign bus.round_idx   = idx_q;
  assign bus.c_out       = c_q;
  assign bus.d_out       = d_q;

`ifdef ROT_CLOSURE_CHECK_EN
  logic [HALF_W-1:0] c_ld;
  logic [HALF_W-1:0] d_ld;
  logic [HALF_W-1:0] c_fin;
  logic [HALF_W-1:0] d_fin;
  logic              chk_q;

  // Decrypt never applied amt(0); undo it here so both modes compare
  // against a full turn.
  always_comb begin
    c_fin = mode ? rot(c_q, 1'b1, SHIFT_ONE_MASK[0]) : c_q;
    d_fin = mode ? rot(d_q, 1'b1, SHIFT_ONE_MASK[0]) : d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_ld  <= '0;
      d_ld  <= '0;
      chk_q <= 1'b0;
    end else begin
      chk_q <= 1'b0;
      if ((state == IDLE) && bus.start) begin
        c_ld <= bus.c_in;
        d_ld <= bus.d_in;
      end
      if (accept_last)
        chk_q <= (c_fin != c_ld) || (d_fin != d_ld);
    end
  end

  assign bus.chk_err = chk_q;
`else
  logic unused_accept_last;
  assign unused_accept_last = accept_last;
  assign bus.chk_err        = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_rotator.sv
module tb_des_key_rotator;

  localparam int          HW     = 28;
  localparam int          ROUNDS = 16;
  localparam int          RW     = 4;
  localparam logic [15:0] MASK   = 16'h8103;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [HW-1:0] c_seen [ROUNDS];
  logic [HW-1:0] d_seen [ROUNDS];

  des_key_rotator_if #(.HALF_W(HW), .RIDX_W(RW)) bus ();

  des_key_rotator #(
    .HALF_W(HW),
    .ROUNDS(ROUNDS),
    .SHIFT_ONE_MASK(MASK),
    .RIDX_W(RW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int amt(input int i);
    return MASK[i] ? 1 : 2;
  endfunction

  function automatic logic [HW-1:0] rotl_n(input logic [HW-1:0] v, input int n);
    int s;
    s = n % HW;
    if (s == 0) return v;
    return (v << s) | (v >> (HW - s));
  endfunction

  // Reference: cumulative rotation from the loaded value to step `step`.
  function automatic logic [HW-1:0] model(input logic [HW-1:0] v, input logic dec, input int step);
    int tot;
    tot = 0;
    if (!dec) begin
      for (int k = 0; k <= step; k++) tot += amt(k);
      return rotl_n(v, tot);
    end
    for (int k = 1; k <= step; k++) tot += amt(ROUNDS - k);
    return rotl_n(v, (HW - (tot % HW)) % HW);
  endfunction

  function automatic logic exp_chk(input logic [HW-1:0] c, input logic [HW-1:0] d);
`ifdef ROT_CLOSURE_CHECK_EN
    int tot;
    tot = 0;
    for (int k = 0; k < ROUNDS; k++) tot += amt(k);
    return (rotl_n(c, tot) != c) || (rotl_n(d, tot) != d);
`else
    return 1'b0 & c[0] & d[0];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_key(input logic [HW-1:0] c, input logic [HW-1:0] d, input logic dec,
                         input int stall_pct, input int stall_idx);
    int   got;
    int   cycles;
    int   held;
    logic rdy;
    got = 0; cycles = 0; held = 0;
    bus.start       = 1'b1;
    bus.decrypt     = dec;
    bus.c_in        = c;
    bus.d_in        = d;
    bus.round_ready = 1'($urandom_range(0, 1));
    tick();
    bus.start   = 1'b0;
    bus.decrypt = 1'($urandom_range(0, 1));
    bus.c_in    = HW'($urandom);
    bus.d_in    = HW'($urandom);
    check("busy_after_start", bus.busy, 1);
    while (got < ROUNDS && cycles < 400) begin
      check("valid", bus.round_valid, 1);
      check("idx", bus.round_idx, got);
      check("c_out", bus.c_out, model(c, dec, got));
      check("d_out", bus.d_out, model(d, dec, got));
      check("done_low", bus.done, 0);
      check("chk_low", bus.chk_err, 0);
      c_seen[got] = bus.c_out;
      d_seen[got] = bus.d_out;
      if (got == stall_idx && held < 5) begin
        rdy = 1'b0;
        held++;
        bus.start = 1'b1;
      end else begin
        rdy = ($urandom_range(0, 99) >= stall_pct);
        bus.start = 1'($urandom_range(0, 1));
      end
      bus.round_ready = rdy;
      tick();
      cycles++;
      if (rdy) got++;
    end
    check("round_timeout", cycles < 400, 1);
    bus.round_ready = 1'($urandom_range(0, 1));
    check("fin_valid", bus.round_valid, 0);
    check("fin_done", bus.done, 1);
    check("fin_busy", bus.busy, 0);
    check("fin_chk", bus.chk_err, exp_chk(c, d));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("post_done", bus.done, 0);
    check("post_valid", bus.round_valid, 0);
    check("post_busy", bus.busy, 0);
    check("post_chk", bus.chk_err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.round_valid, 0);
    check({tag, "_idx"}, bus.round_idx, 0);
    check({tag, "_c"}, bus.c_out, 0);
    check({tag, "_d"}, bus.d_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_chk"}, bus.chk_err, 0);
  endtask

  initial begin
    // Reset with start asserted
    rst_n           = 1'b0;
    bus.start       = 1'b1;
    bus.decrypt     = 1'b0;
    bus.c_in        = 28'h1234567;
    bus.d_in        = 28'h7654321;
    bus.round_ready = 1'b1;
    repeat (3) tick();
    check_all_zero("rst");
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (2) tick();
    check_all_zero("idle");

    // Encrypt, default mask, full-speed consumer
    run_key(28'h0000001, 28'h8000000, 1'b0, 0, -1);
    check("enc_c0", c_seen[0], 28'h0000002);
    check("enc_c1", c_seen[1], 28'h0000004);
    check("enc_c2", c_seen[2], 28'h0000010);
    check("enc_d0", d_seen[0], 28'h0000001);
    check("enc_c15", c_seen[15], 28'h0000001);

    // Decrypt, same inputs
    run_key(28'h0000001, 28'h8000000, 1'b1, 0, -1);
    check("dec_c0", c_seen[0], 28'h0000001);
    check("dec_c1", c_seen[1], 28'h8000000);
    check("dec_c2", c_seen[2], 28'h2000000);
    check("dec_c15", c_seen[15], 28'h0000002);

    // Five-cycle stall at idx 3 with start pulsed during it
    run_key(HW'($urandom), HW'($urandom), 1'b0, 0, 3);
    run_key(HW'($urandom), HW'($urandom), 1'b1, 0, 3);

    // Randomized keys, modes and back-pressure
    for (int n = 0; n < 8; n++)
      run_key(HW'($urandom), HW'($urandom), 1'($urandom_range(0, 1)), 35, -1);

    // Asynchronous reset at idx 7
    bus.start       = 1'b1;
    bus.decrypt     = 1'b0;
    bus.c_in        = 28'hABCDEF1;
    bus.d_in        = 28'h1FEDCBA;
    tick();
    bus.start       = 1'b0;
    bus.round_ready = 1'b1;
    repeat (7) tick();
    check("abort_idx", bus.round_idx, 7);
    check("abort_c", bus.c_out, model(28'hABCDEF1, 1'b0, 7));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) begin
      tick();
      check("abort_hold_done", bus.done, 0);
    end
    rst_n           = 1'b1;
    bus.round_ready = 1'b0;
    tick();
    check_all_zero("abort_rel");
    tick();
    check("abort_rel_done", bus.done, 0);

    // Fresh load after the abort starts from idx 0
    run_key(28'h5A5A5A5, 28'h0F0F0F0, 1'b1, 20, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_rotator.md
Name: des_key_rotator

Overview:
Parametrised DES key-schedule rotator and successor to the single-step left-shift stage. Loads the 28-bit C/D halves after PC-1 and emits one rotated C/D pair per round for ROUNDS rounds. Per-round shift amounts come from a programmable schedule, and the block supports both encrypt (rotate-left) and decrypt (rotate-right) order. Output uses a valid/ready handshake, so the downstream PC-2/round logic can stall it.

Parameters:
HALF_W, 28, width of each half (C and D)
ROUNDS, 16, number of subkeys produced per key load
SHIFT_ONE_MASK, 16'h8103, bit i = 1 means step i rotates by 1, bit i = 0 means it rotates by 2 (DES: steps 0, 1, 8, 15 rotate by 1); width ROUNDS
RIDX_W, 4, width of round index; must satisfy 2^RIDX_W >= ROUNDS

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  load request; honoured only in IDLE
decrypt  in  1  mode, sampled with start: 0 = encrypt, 1 = decrypt
c_in  in  HALF_W  C half, sampled with start
d_in  in  HALF_W  D half, sampled with start
round_ready  in  1  consumer accepts current round
round_valid  out  1  c_out/d_out/round_idx hold a valid round
round_idx  out  RIDX_W  step index 0..ROUNDS-1 of current output
c_out  out  HALF_W  rotated C for current round
d_out  out  HALF_W  rotated D for current round
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the final round is accepted
chk_err  out  1  rotation-closure error (see Optional Feature)

Behaviour:
- Reset (async, rst_n = 0): state IDLE; c_out = d_out = 0; round_idx = 0; round_valid = busy = done = chk_err = 0. Reset mid-sequence aborts immediately, and no done pulse is issued.
- amt(i) = 1 if SHIFT_ONE_MASK[i] else 2.
- Encrypt, step i: value = previous value rotated left by amt(i). Step 0's previous value is the loaded value.
- Decrypt, step 0: rotation 0, so the loaded value is output unchanged. Step i >= 1: previous value rotated right by amt(ROUNDS-i).
- C and D always rotate identically. Rotate-by-2 is a single-cycle operation.
- States:
  - IDLE: start = 1 latches mode/c_in/d_in, computes step 0, and moves to OUT. round_valid rises the next cycle, so latency is 1 clock.
  - OUT: round_valid = 1; outputs are held stable while round_ready = 0.
    - On round_valid & round_ready with round_idx < ROUNDS-1: the next cycle presents step round_idx+1, and round_valid stays 1. Back-to-back acceptance gives 1 round/clock.
    - On acceptance with round_idx = ROUNDS-1: go to FIN, and round_valid = 0 the next cycle.
  - FIN: done = 1 and busy = 0 for one cycle, then return to IDLE.
- busy = 1 in OUT.
- start while busy or in FIN is ignored, with no effect on outputs.
- start and round_ready are independent; round_ready while round_valid = 0 is ignored.
- Index wrap: round_idx never exceeds ROUNDS-1. It returns to 0 only on the next load.
- Schedule masks whose total rotation is not HALF_W are legal; the rotator still runs them, and closure is not guaranteed.

Optional Feature:
- Macro ROT_CLOSURE_CHECK_EN.
- Defined: when entering FIN, the block compares the final C/D against the loaded C/D.
  - Encrypt: final rotated 0 positions.
  - Decrypt: final rotated right by amt(0).
  - On mismatch, chk_err = 1 for the FIN cycle.
  - Default DES mask always yields chk_err = 0; a mask summing to a value other than HALF_W yields chk_err = 1.
- Not defined: chk_err is tied to 0 and no comparison logic or loaded-copy register is built. c_out/d_out/handshake timing is identical in both builds.

Test Plan:
1. Reset/idle: rst_n low for 3 clocks, start high during reset → all outputs 0; after release with start = 0, outputs stay 0.
2. Encrypt, default mask, c_in = 28'h0000001, d_in = 28'h8000000, round_ready = 1 → c_out sequence 0000002, 0000004, 0000010, …; step 0 d_out = 0000001; step 15 c_out = 0000001; done pulses exactly 1 cycle after idx 15; 16 valid cycles total.
3. Decrypt, same inputs → step 0 c_out = 0000001; step 1 c_out = 8000000 (right 1); step 2 c_out = 2000000 (right 2); step 15 c_out = 0000002; done pulses once.
4. Back-pressure: round_ready = 0 for 5 cycles at idx 3, and start pulsed during the stall → idx/c_out/d_out unchanged and start ignored; after release, idx 4 is presented the next cycle.
5. Async reset asserted mid-sequence at idx 7 → outputs clear without waiting for a clock edge; no done; next start begins at idx 0.
6. ROT_CLOSURE_CHECK_EN defined, SHIFT_ONE_MASK = 16'hFFFF (sum 16) → chk_err = 1 in FIN cycle only. Default mask → chk_err stays 0. Macro undefined → chk_err is always 0.
